// File: rtl/uart_loader.sv
// Byte-stream packet loader: SYNC, ADDR_H, ADDR_L, LEN, data..., CHK -> memory writes.
// Data bytes are written at base+index; XOR checksum decides pkt_ok vs pkt_err.
module uart_loader #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic        busy,
  output logic        pkt_ok,
  output logic        pkt_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CHK
  } state_t;

  state_t      r_state, w_next;
  logic        r_rx_prev;
  logic [15:0] r_addr;
  logic [8:0]  r_cnt;
  logic [7:0]  r_xor;
  logic [7:0]  r_chk_rx;
  logic        r_chk_have;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_data;
  logic        r_pkt_ok, r_pkt_err;
  logic [TW-1:0] r_tmo;

  logic w_evt, w_pending, w_tmo, w_ok, w_err, w_write, w_abort;

  assign w_evt     = rx_valid & ~r_rx_prev;
  assign w_pending = r_mem_we & ~mem_ready;
  assign w_tmo     = (r_tmo >= TW'(TIMEOUT_CLKS));

  always_comb begin
    w_next  = r_state;
    w_ok    = 1'b0;
    w_err   = 1'b0;
    w_write = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE:   if (w_evt && rx_byte == SYNC_BYTE) w_next = S_ADDR_H;
      S_ADDR_H: if (w_evt) w_next = S_ADDR_L;
      S_ADDR_L: if (w_evt) w_next = S_LEN;
      S_LEN:    if (w_evt) w_next = S_DATA;
      S_DATA: begin
        if (w_evt) begin
          if (w_pending) begin
            w_err   = 1'b1;
            w_abort = 1'b1;
            w_next  = S_IDLE;
          end else begin
            w_write = 1'b1;
            if (r_cnt == 9'd1) w_next = S_CHK;
          end
        end
      end
      S_CHK: begin
        // The checksum byte is parked until the final data write has been accepted.
        if (r_chk_have && !r_mem_we) begin
          w_next = S_IDLE;
          if (r_chk_rx == r_xor) w_ok = 1'b1;
          else                   w_err = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && !w_evt && w_tmo && !w_ok && !w_err) begin
      w_err  = 1'b1;
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rx_prev  <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_xor      <= '0;
      r_chk_rx   <= '0;
      r_chk_have <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_pkt_ok   <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_state   <= w_next;
      r_rx_prev <= rx_valid;
      r_pkt_ok  <= w_ok;
      r_pkt_err <= w_err;

      if (w_evt || r_state == S_IDLE) r_tmo <= '0;
      else if (!w_pending)            r_tmo <= r_tmo + TW'(1);

      if (w_abort)                    r_mem_we <= 1'b0;
      else if (w_write)               r_mem_we <= 1'b1;
      else if (r_mem_we && mem_ready) r_mem_we <= 1'b0;

      if (r_state == S_IDLE) begin
        r_xor      <= '0;
        r_chk_have <= 1'b0;
      end else if (w_evt) begin
        case (r_state)
          S_ADDR_H: begin
            r_addr[15:8] <= rx_byte;
            r_xor        <= r_xor ^ rx_byte;
          end
          S_ADDR_L: begin
            r_addr[7:0] <= rx_byte;
            r_xor       <= r_xor ^ rx_byte;
          end
          S_LEN: begin
            r_cnt <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
            r_xor <= r_xor ^ rx_byte;
          end
          S_DATA: begin
            if (w_write) begin
              r_mem_addr <= r_addr;
              r_mem_data <= rx_byte;
              r_addr     <= r_addr + 16'd1;
              r_cnt      <= r_cnt - 9'd1;
              r_xor      <= r_xor ^ rx_byte;
            end
          end
          S_CHK: begin
            if (!r_chk_have) begin
              r_chk_rx   <= rx_byte;
              r_chk_have <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign busy     = (r_state != S_IDLE);
  assign pkt_ok   = r_pkt_ok;
  assign pkt_err  = r_pkt_err;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed scenarios plus random packets,
// checked against a packet-level model (expected writes and XOR checksum).
module tb_uart_loader;
  localparam int unsigned TMO = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        busy, pkt_ok, pkt_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  uart_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .pkt_ok(pkt_ok), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  // mem_ready: 0 = always ready, 1 = random with at most 2 stalled cycles, 2 = never ready
  int unsigned rdy_mode = 0;
  int unsigned low_run  = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      0: mem_ready = 1'b1;
      2: mem_ready = 1'b0;
      default: begin
        if (low_run >= 2) begin
          mem_ready = 1'b1;
          low_run   = 0;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
          low_run   = mem_ready ? 0 : low_run + 1;
        end
      end
    endcase
  end

  logic [23:0] wq[$];
  int unsigned ok_cnt = 0, err_cnt = 0;
  time         t_acc = 0, t_ok = 0, t_err = 0, t_evt = 0;
  bit          both_seen = 0, stab_bad = 0;
  logic        prev_we = 0, prev_acc = 0;
  logic [23:0] prev_ad = '0;

  always @(negedge clk) begin
    #2;
    if (mem_we && mem_ready) begin
      wq.push_back({mem_addr, mem_data});
      t_acc = $time;
    end
    if (pkt_ok)  begin ok_cnt++;  t_ok  = $time; end
    if (pkt_err) begin err_cnt++; t_err = $time; end
    if (pkt_ok && pkt_err) both_seen = 1;
    if (prev_we && !prev_acc && mem_we && {mem_addr, mem_data} !== prev_ad) stab_bad = 1;
    prev_we  = mem_we;
    prev_acc = mem_we && mem_ready;
    prev_ad  = {mem_addr, mem_data};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned width, input int unsigned gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    t_evt    = $time + 5;
    repeat (width) @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_packet(input string tag, input logic [7:0] pre[$], input logic [15:0] addr,
                            input logic [7:0] data[$], input bit force_bad,
                            input int unsigned width, input int unsigned gap);
    logic [7:0]  x, chkb;
    int unsigned b_w, b_ok, b_err, n;
    n = data.size();
    x = addr[15:8] ^ addr[7:0] ^ 8'(n);
    foreach (data[i]) x ^= data[i];
    chkb = force_bad ? (x ^ 8'($urandom_range(1, 255))) : x;
    b_w = wq.size(); b_ok = ok_cnt; b_err = err_cnt;
    foreach (pre[i]) send_byte(pre[i], width, gap);
    send_byte(8'hA5, width, gap);
    send_byte(addr[15:8], width, gap);
    send_byte(addr[7:0], width, gap);
    send_byte(8'(n), width, gap);
    foreach (data[i]) send_byte(data[i], width, gap);
    send_byte(chkb, width, gap);
    repeat (10) @(negedge clk);
    chk({tag, "_nwr"}, wq.size() - b_w, n);
    if (wq.size() - b_w == n)
      foreach (data[i]) chk({tag, "_wr"}, wq[b_w + i], {16'(addr + i), data[i]});
    chk({tag, "_ok"}, ok_cnt - b_ok, force_bad ? 0 : 1);
    chk({tag, "_err"}, err_cnt - b_err, force_bad ? 1 : 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [7:0]  none[$];
    logic [7:0]  garb[$];
    logic [7:0]  d[$];
    int unsigned b_w, b_ok, b_err;

    reset = 1'b1; rx_valid = 1'b0; rx_byte = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ok", pkt_ok, 0);
    chk("rst_err", pkt_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic packet; the XOR of 12 34 02 AA BB is 0x35.
    d.delete(); d.push_back(8'hAA); d.push_back(8'hBB);
    run_packet("basic", none, 16'h1234, d, 0, 1, 2);
    run_packet("badchk", none, 16'h1234, d, 1, 1, 2);
    garb.push_back(8'h00); garb.push_back(8'hFF);
    run_packet("wide", garb, 16'h1234, d, 0, 2, 2);
    d.delete(); d.push_back(8'h11); d.push_back(8'h22);
    run_packet("wrap", none, 16'hFFFF, d, 0, 1, 2);
    d.delete(); d.push_back(8'hA5); d.push_back(8'h01); d.push_back(8'hA5);
    run_packet("midsync", none, 16'h0100, d, 0, 1, 2);

    // Timeout after a header with no data
    b_w = wq.size(); b_ok = ok_cnt; b_err = err_cnt;
    send_byte(8'hA5, 1, 1);
    send_byte(8'h00, 1, 1);
    send_byte(8'h10, 1, 1);
    repeat (3) @(negedge clk);
    #2 chk("tmo_busy_mid", busy, 1);
    repeat (TMO + 5) @(negedge clk);
    chk("tmo_err", err_cnt - b_err, 1);
    chk("tmo_ok", ok_cnt - b_ok, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_nwr", wq.size() - b_w, 0);
    chk("tmo_time", (t_err >= t_evt + (TMO - 1) * 10) && (t_err <= t_evt + (TMO + 3) * 10), 1);

    // Overrun: memory never ready, second data byte arrives while first is pending
    rdy_mode = 2;
    @(negedge clk);
    b_w = wq.size(); b_ok = ok_cnt; b_err = err_cnt;
    send_byte(8'hA5, 1, 2); send_byte(8'h00, 1, 2); send_byte(8'h20, 1, 2);
    send_byte(8'h02, 1, 2); send_byte(8'h33, 1, 2); send_byte(8'h44, 1, 2);
    repeat (4) @(negedge clk);
    chk("ovr_err", err_cnt - b_err, 1);
    chk("ovr_ok", ok_cnt - b_ok, 0);
    chk("ovr_we", mem_we, 0);
    chk("ovr_busy", busy, 0);
    chk("ovr_nwr", wq.size() - b_w, 0);

    // Checksum arrives while the last write is stalled; the verdict must wait for it
    b_w = wq.size(); b_ok = ok_cnt; b_err = err_cnt;
    send_byte(8'hA5, 1, 2); send_byte(8'h30, 1, 2); send_byte(8'h00, 1, 2);
    send_byte(8'h01, 1, 2); send_byte(8'h5A, 1, 2);
    send_byte(8'h30 ^ 8'h00 ^ 8'h01 ^ 8'h5A, 1, 2);
    repeat (5) @(negedge clk);
    chk("stall_ok_early", ok_cnt - b_ok, 0);
    chk("stall_busy", busy, 1);
    chk("stall_we", mem_we, 1);
    rdy_mode = 0;
    repeat (6) @(negedge clk);
    chk("stall_ok", ok_cnt - b_ok, 1);
    chk("stall_err", err_cnt - b_err, 0);
    chk("stall_nwr", wq.size() - b_w, 1);
    if (wq.size() - b_w == 1) chk("stall_wr", wq[b_w], {16'h3000, 8'h5A});
    chk("stall_order", t_ok > t_acc, 1);

    // Reset in the middle of the data phase
    b_ok = ok_cnt; b_err = err_cnt;
    send_byte(8'hA5, 1, 2); send_byte(8'h12, 1, 2); send_byte(8'h34, 1, 2);
    send_byte(8'h04, 1, 2); send_byte(8'hAA, 1, 2); send_byte(8'hBB, 1, 0);
    reset = 1'b1;
    #2;
    chk("mrst_we", mem_we, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_data", mem_data, 0);
    chk("mrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_ok", ok_cnt - b_ok, 0);
    chk("mrst_err", err_cnt - b_err, 0);
    d.delete(); d.push_back(8'hC3); d.push_back(8'h3C);
    run_packet("after_rst", none, 16'h4000, d, 0, 1, 2);

    // Random packets, random memory back-pressure
    for (int k = 0; k < 8; k++) begin
      d.delete();
      repeat ($urandom_range(1, 6)) d.push_back(8'($urandom));
      rdy_mode = $urandom_range(0, 1);
      run_packet($sformatf("rnd%0d", k), none, 16'($urandom), d, 1'($urandom_range(0, 1)),
                 $urandom_range(1, 3), 5);
    end

    // LEN = 0 carries 256 bytes, crossing the address wrap
    d.delete();
    repeat (256) d.push_back(8'($urandom));
    rdy_mode = 1;
    run_packet("len256", none, 16'hFF80, d, 0, 1, 5);
    rdy_mode = 0;

    chk("never_both", both_seen, 0);
    chk("addr_stable", stab_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
